imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream program loader that writes the instruction memory the CPU core fetches from. It accepts a valid/ready byte stream (count header, big-endian 24-bit instructions, optional checksum) and turns it into sequential 24-bit write cycles on the imem write port. It holds the CPU core stalled (`cpu_hold`) from reset until a load completes cleanly.

## Interface
- `ADDR_W`, 8, imem address width; max program length 2**ADDR_W instructions.
- `INSN_W`, 24, instruction width; fixed at 24, i.e. 3 bytes per instruction.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `restart`  in  1  single-cycle pulse; aborts any session and restarts loading.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `imem_we`  out  1  imem write strobe, one cycle per instruction.
- `imem_addr`  out  ADDR_W  imem write address.
- `imem_wdata`  out  INSN_W  imem write data.
- `cpu_hold`  out  1  high keeps the PC/core stalled.
- `done`  out  1  load completed successfully.
- `err`  out  1  load failed; sticky until `restart` or `rst`.

## Operation
- States: HDR, DATA, WR, CHK, DONE, ERR.
- **HDR:** `in_ready`=1. The accepted byte is the instruction count N.
  - N=0 or N>2**ADDR_W: go to ERR.
  - Otherwise latch N, clear the address counter and byte index, go to DATA.
- **DATA:** `in_ready`=1. Accepted bytes shift into a 24-bit assembly register, MSB first (byte 0 → bits 23:16).
  - On the 3rd byte, go to WR.
- **WR:** one cycle, `in_ready`=0.
  - Drive `imem_we`=1, `imem_addr`=address counter, `imem_wdata`=assembled word.
  - Then increment the address.
  - If N instructions have been written, go to CHK (or DONE when checksum is compiled out); else go to DATA.
- **CHK:** `in_ready`=1. The accepted byte is compared with the running XOR of the count byte and all data bytes.
  - Match: go to DONE. Mismatch: go to ERR.
- **DONE:** `in_ready`=0, `cpu_hold`=0, `done`=1. Stays here until `restart` or `rst`.
- **ERR:** `in_ready`=0, `cpu_hold`=1, `err`=1. Stays here until `restart` or `rst`. Already-written imem words are not erased.
- `restart` is honored in every state:
  - next state HDR, `cpu_hold`=1, `done`/`err` cleared, counters and checksum cleared.
  - A byte handshaked in the same cycle as `restart` is discarded.
- The address counter is ADDR_W+1 bits wide internally, so N=2**ADDR_W ends without wrap. `imem_addr` is its low ADDR_W bits.

## Timing
- Reset values:
  - state=HDR, `in_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `cpu_hold`=1, `done`=0, `err`=0
- All outputs are registered or decoded from registered state only; no combinational path from `in_valid` to `in_ready`.
- `imem_we` pulses exactly one cycle, in the cycle after the 3rd byte of an instruction is accepted. `imem_addr`/`imem_wdata` are stable in that cycle.
- Peak throughput: one instruction per 4 cycles (3 accept + 1 WR).
- `cpu_hold` falls in the same cycle `done` rises: one cycle after the checksum byte is accepted, or one cycle after the last WR when checksum is compiled out.
- `rst` mid-session: immediate return to reset values. An imem write in flight that cycle is suppressed (`imem_we` forced 0).
- A stall (`in_valid`=0) in any accepting state holds all state indefinitely.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CHK state present; one trailing XOR checksum byte is required; mismatch goes to ERR.
- Undefined:
  - CHK and the XOR accumulator are absent.
  - The last WR goes straight to DONE.
  - Any checksum byte sent is ignored, because `in_ready`=0 in DONE.

## Test plan
- N=2, bytes 0x12 0x34 0x56, 0xAB 0xCD 0xEF, checksum 0x02^0x12^0x34^0x56^0xAB^0xCD^0xEF:
  - writes addr0=0x123456, addr1=0xABCDEF, each a 1-cycle `imem_we`
  - then `done`=1, `cpu_hold`=0.
- Same stream with checksum byte inverted → no further writes after addr1, `err`=1, `cpu_hold`=1, `in_ready`=0.
- Header 0x00 → ERR the cycle after acceptance, zero `imem_we` pulses.
- Random `in_valid` gaps across N=3 → the same three words and addresses as the gapless run; `in_ready` low only in WR cycles.
- `restart` after byte 2 of instruction 1, then a full N=1 stream → exactly one write, to addr0, with the new data.
- `rst` asserted in a WR cycle → `imem_we`=0 that cycle, all outputs at reset values, next accepted byte treated as header.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader writing 24-bit instructions to imem; optional checksum via IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int INSN_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INSN_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {HDR, DATA, WR, CHK, DONE, ERR} state_t;
  state_t state, state_n;
  logic [ADDR_W:0] n_q, addr;
  logic [1:0] idx;
  logic [INSN_W-1:0] word;
  logic hdr_bad, last;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  localparam state_t AFTER_WR = CHK;
`else
  localparam state_t AFTER_WR = DONE;
`endif
  assign hdr_bad = in_data == 8'd0 || 32'(in_data) > (32'd1 << ADDR_W);
  assign last = addr + (ADDR_W+1)'(1) == n_q;
  assign in_ready = state == HDR || state == DATA || state == CHK;
  assign imem_we = state == WR;
  assign imem_addr = addr[ADDR_W-1:0];
  assign imem_wdata = word;
  assign cpu_hold = state != DONE;
  assign done = state == DONE;
  assign err = state == ERR;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= HDR;
    else state <= state_n;
  // next-state decode; restart overrides everything, discarding any same-cycle byte
  always_comb begin
    state_n = state;
    if (restart) state_n = HDR;
    else
      case (state)
        HDR:  if (in_valid) state_n = hdr_bad ? ERR : DATA;
        DATA: if (in_valid && idx == 2'd2) state_n = WR;
        WR:   state_n = last ? AFTER_WR : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK:  if (in_valid) state_n = in_data == csum ? DONE : ERR;
`endif
        default: ;
      endcase
  end
  // count, address, byte assembly and running checksum
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      n_q <= '0;
      addr <= '0;
      idx <= '0;
      word <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else if (restart) begin
      n_q <= '0;
      addr <= '0;
      idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      if (state == HDR && in_valid) begin
        n_q <= (ADDR_W+1)'(in_data);
        addr <= '0;
        idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= in_data;
`endif
      end
      if (state == DATA && in_valid) begin
        word <= {word[INSN_W-9:0], in_data};
        idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ in_data;
`endif
      end
      if (state == WR) addr <= addr + (ADDR_W+1)'(1);
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader
module tb_imem_loader;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  logic clk = 0, rst = 1, restart = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, imem_we, cpu_hold, done, err;
  logic [7:0] imem_addr;
  logic [23:0] imem_wdata;
  logic [31:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;

  imem_loader dut (.clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clk) if (!rst) begin
    check("hold_is_not_done", 32'(cpu_hold), 32'(!done));
    if (imem_we) begin
      if (exp_q.size() == 0) check("unexpected_write", {imem_addr, imem_wdata}, 32'hxxxxxxxx);
      else check("write", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_valid = 1;
    in_data = b;
    while (!in_ready && t < 20) begin
      if (!imem_we) check("ready_low_outside_wr", 32'(in_ready), 32'(1));
      @(negedge clk);
      t++;
    end
    if (t == 20) check("send_timeout", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic send_ignored(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1;
    in_data = b;
    repeat (3) begin
      @(negedge clk);
      check("csum_ignored_ready", 32'(in_ready), 32'(0));
    end
    in_valid = 0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1;
    in_valid = 1;
    in_data = 8'h05;
    @(posedge clk);
    #1 restart = 0;
    in_valid = 0;
    @(negedge clk);
    check("restart_ready", 32'(in_ready), 32'(1));
    check("restart_flags", {cpu_hold, done, err}, 32'b100);
  endtask

  task automatic wait_end(input bit exp_err);
    int t = 0;
    @(negedge clk);
    while (!(done || err) && t < 8) begin
      @(negedge clk);
      t++;
    end
    check("end_done", 32'(done), 32'(!exp_err));
    check("end_err", 32'(err), 32'(exp_err));
    check("end_hold", 32'(cpu_hold), 32'(exp_err));
    check("end_ready", 32'(in_ready), 32'(0));
    check("pending_writes", exp_q.size(), 0);
  endtask

  // reference: program i lands at address i; checksum is XOR of count and every data byte
  task automatic load(input logic [23:0] w[$], input bit gaps, input bit bad_csum);
    logic [7:0] cs = 8'(w.size());
    foreach (w[i]) begin
      exp_q.push_back({8'(i), w[i]});
      cs = cs ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
    end
    send(8'(w.size()));
    foreach (w[i])
      for (int k = 2; k >= 0; k--) begin
        if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send(w[i][k*8 +: 8]);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(bad_csum ? ~cs : cs);
`else
    send_ignored(bad_csum ? ~cs : cs);
`endif
    wait_end(bad_csum && CSUM);
  endtask

  function automatic void rand_prog(input int n, output logic [23:0] w[$]);
    w = {};
    for (int i = 0; i < n; i++) w.push_back(24'($urandom));
  endfunction

  initial begin
    logic [23:0] p[$];
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'(1));
    check("rst_outputs", {imem_we, imem_addr, imem_wdata[22:0]}, 32'(0));
    check("rst_flags", {cpu_hold, done, err}, 32'b100);
    rst = 0;
    p = '{24'h123456, 24'hABCDEF};
    load(p, 0, 0);
    do_restart();
    load(p, 0, 1);
    do_restart();
    send(8'h00);
    @(negedge clk);
    check("hdr0_err", {err, done, cpu_hold, in_ready}, 32'b1010);
    check("hdr0_no_writes", exp_q.size(), 0);
    do_restart();
    rand_prog(3, p);
    load(p, 1, 0);
    for (int r = 0; r < 6; r++) begin
      do_restart();
      rand_prog($urandom_range(1, 6), p);
      load(p, 1, $urandom_range(0, 3) == 0);
    end
    do_restart();
    send(8'd2);
    p = '{24'h0A0B0C};
    exp_q.push_back({8'd0, p[0]});
    send(8'h0A); send(8'h0B); send(8'h0C);
    send(8'h11); send(8'h22);
    do_restart();
    p = '{24'h778899};
    load(p, 0, 0);
    do_restart();
    send(8'd1); send(8'hDE); send(8'hAD); send(8'hBE);
    check("wr_before_rst", 32'(imem_we), 32'(1));
    rst = 1;
    #1;
    check("rst_in_wr_we", 32'(imem_we), 32'(0));
    check("rst_in_wr_outputs", {imem_addr, imem_wdata}, 32'(0));
    check("rst_in_wr_flags", {in_ready, cpu_hold, done, err}, 32'b1100);
    @(negedge clk);
    rst = 0;
    p = '{24'h445566};
    load(p, 0, 0);
    do_restart();
    rand_prog(255, p);
    load(p, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
